sample_accumulator: RTL and testbench



---
 rtl/sample_accumulator.sv | 138 +++++++++++++
 tb/tb_sample_accumulator.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_accumulator.sv
// Batch accumulator: sums NUM_SAMPLES unsigned samples through adder_nbit and holds the total until acknowledged.
// Optional build macro SAMPLE_ACCUMULATOR_SATURATE_EN clamps the total to all-ones on carry instead of wrapping.

module adder_nbit #(
    parameter int BIT_WIDTH = 8
) (
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 carry_in,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 overflow
);

    // Overflow is the unsigned carry out of the top bit.
    assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {{BIT_WIDTH{1'b0}}, carry_in};

endmodule

module sample_accumulator #(
    parameter int BIT_WIDTH   = 8,
    parameter int NUM_SAMPLES = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 clear,
    input  logic [BIT_WIDTH-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic [BIT_WIDTH-1:0] result,
    output logic                 result_valid,
    input  logic                 result_ack,
    output logic                 overflow_flag,
    output logic [7:0]           sample_count
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t               state;
    logic [BIT_WIDTH-1:0] acc;
    logic [BIT_WIDTH-1:0] sum;
    logic [BIT_WIDTH-1:0] acc_next;
    logic                 carry;
    logic [7:0]           count;
    logic [8:0]           count_inc;
    logic                 accept;
    logic                 last_sample;

    adder_nbit #(
        .BIT_WIDTH(BIT_WIDTH)
    ) u_adder (
        .a       (acc),
        .b       (data_in),
        .carry_in(1'b0),
        .sum     (sum),
        .overflow(carry)
    );

    assign accept      = data_valid && data_ready;
    assign count_inc   = {1'b0, count} + 9'd1;
    assign last_sample = (count_inc == 9'(NUM_SAMPLES));

`ifdef SAMPLE_ACCUMULATOR_SATURATE_EN
    // Once a batch has saturated it stays pinned at all-ones until the batch ends.
    logic saturated;

    assign acc_next = (carry || saturated) ? {BIT_WIDTH{1'b1}} : sum;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            saturated <= 1'b0;
        end else if (clear || (state == DONE && result_ack)) begin
            saturated <= 1'b0;
        end else if (accept && state != DONE) begin
            saturated <= saturated | carry;
        end
    end
`else
    assign acc_next = sum;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            acc           <= '0;
            count         <= '0;
            overflow_flag <= 1'b0;
        end else if (clear) begin
            // Abort wins over any sample or acknowledge presented in the same cycle.
            state         <= IDLE;
            acc           <= '0;
            count         <= '0;
            overflow_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc           <= acc_next;
                        count         <= 8'd1;
                        overflow_flag <= carry;
                        state         <= (NUM_SAMPLES == 1) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc           <= acc_next;
                        count         <= count_inc[7:0];
                        overflow_flag <= overflow_flag | carry;
                        if (last_sample) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (result_ack) begin
                        acc           <= '0;
                        count         <= '0;
                        overflow_flag <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign data_ready   = (state != DONE);
    assign result_valid = (state == DONE);
    assign result       = (state == DONE) ? acc : '0;
    assign sample_count = count;

endmodule

// File: tb/tb_sample_accumulator.sv
// Scoreboard bench for sample_accumulator: a 4-sample instance and a 1-sample instance share clock and reset.

module tb_sample_accumulator;

    logic       clk;
    logic       n_rst;
    logic       clear;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic [7:0] result;
    logic       result_valid;
    logic       result_ack;
    logic       overflow_flag;
    logic [7:0] sample_count;

    logic       clear1;
    logic [7:0] data_in1;
    logic       data_valid1;
    logic       data_ready1;
    logic [7:0] result1;
    logic       result_valid1;
    logic       result_ack1;
    logic       overflow_flag1;
    logic [7:0] sample_count1;

    int total;
    int bad;

    typedef struct {
        logic [7:0] value;
        logic       ovf;
    } exp_t;

    exp_t sb[$];

    logic [7:0] m_acc;
    logic       m_ovf;
    logic       m_sat;
    int         m_count;

    sample_accumulator #(.BIT_WIDTH(8), .NUM_SAMPLES(4)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .result       (result),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .overflow_flag(overflow_flag),
        .sample_count (sample_count)
    );

    sample_accumulator #(.BIT_WIDTH(8), .NUM_SAMPLES(1)) dut1 (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear1),
        .data_in      (data_in1),
        .data_valid   (data_valid1),
        .data_ready   (data_ready1),
        .result       (result1),
        .result_valid (result_valid1),
        .result_ack   (result_ack1),
        .overflow_flag(overflow_flag1),
        .sample_count (sample_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        m_acc   = 8'd0;
        m_ovf   = 1'b0;
        m_sat   = 1'b0;
        m_count = 0;
    endtask

    // Reference for one accepted sample on the 4-sample instance.
    task automatic model_add(input logic [7:0] v);
        logic [8:0] s;
        exp_t       e;
        s = {1'b0, m_acc} + {1'b0, v};
`ifdef SAMPLE_ACCUMULATOR_SATURATE_EN
        if (s[8] || m_sat) begin
            m_acc = 8'hFF;
            m_sat = 1'b1;
        end else begin
            m_acc = s[7:0];
        end
`else
        m_acc = s[7:0];
`endif
        m_ovf   = m_ovf | s[8];
        m_count = m_count + 1;
        if (m_count == 4) begin
            e.value = m_acc;
            e.ovf   = m_ovf;
            sb.push_back(e);
        end
    endtask

    task automatic send(input logic [7:0] v);
        data_in    = v;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        model_add(v);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    // Pop the oldest expected batch once result_valid shows, within a bounded wait.
    task automatic pop_result(input string name);
        exp_t e;
        int   waited;
        waited = 0;
        while (!result_valid && waited < 10) begin
            idle_cycle();
            waited++;
        end
        total++;
        if (!result_valid) begin
            bad++;
            $display("FAIL %s_timeout: result_valid=%0d required 1", name, result_valid);
        end else if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s_unexpected: result=%0d with empty scoreboard", name, result);
        end else begin
            e = sb.pop_front();
            if (result !== e.value) begin
                bad++;
                $display("FAIL %s_result: got %0d required %0d", name, result, e.value);
            end
            total++;
            if (overflow_flag !== e.ovf) begin
                bad++;
                $display("FAIL %s_ovf: got %0d required %0d", name, overflow_flag, e.ovf);
            end
        end
    endtask

    task automatic do_ack(input string name);
        result_ack = 1'b1;
        @(posedge clk);
        #1;
        result_ack = 1'b0;
        model_clear();
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL %s_valid: got %0d required 0", name, result_valid); end
        total++; if (data_ready !== 1'b1) begin bad++; $display("FAIL %s_ready: got %0d required 1", name, data_ready); end
        total++; if (sample_count !== 8'd0) begin bad++; $display("FAIL %s_count: got %0d required 0", name, sample_count); end
        total++; if (result !== 8'd0) begin bad++; $display("FAIL %s_result: got %0d required 0", name, result); end
    endtask

    task automatic test_reset();
        send(8'd3);
        send(8'd4);
        #2;
        n_rst = 1'b0;
        #1;
        total++; if (result !== 8'd0) begin bad++; $display("FAIL reset_result: got %0d required 0", result); end
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0d required 0", result_valid); end
        total++; if (overflow_flag !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %0d required 0", overflow_flag); end
        total++; if (sample_count !== 8'd0) begin bad++; $display("FAIL reset_count: got %0d required 0", sample_count); end
        total++; if (data_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0d required 1", data_ready); end
        model_clear();
        @(negedge clk);
        n_rst = 1'b1;
        idle_cycle();
    endtask

    task automatic test_basic();
        send(8'd10);
        send(8'd20);
        send(8'd30);
        send(8'd40);
        total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL basic_latency: result_valid=%0d required 1", result_valid); end
        total++; if (sample_count !== 8'd4) begin bad++; $display("FAIL basic_count: got %0d required 4", sample_count); end
        total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL basic_ready: got %0d required 0", data_ready); end
        pop_result("basic");
        do_ack("basic_ack");
    endtask

    task automatic test_wrap();
        send(8'd200);
        send(8'd100);
        send(8'd1);
        send(8'd1);
        pop_result("wrap");
        do_ack("wrap_ack");
    endtask

    task automatic test_gaps();
        logic [7:0] steps [6];
        steps = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4};
        send(8'd5);
        total++; if (sample_count !== steps[0]) begin bad++; $display("FAIL gap_step0: got %0d required %0d", sample_count, steps[0]); end
        // An acknowledge outside DONE must be ignored.
        result_ack = 1'b1;
        idle_cycle();
        result_ack = 1'b0;
        total++; if (sample_count !== steps[1]) begin bad++; $display("FAIL gap_step1: got %0d required %0d", sample_count, steps[1]); end
        idle_cycle();
        total++; if (sample_count !== steps[2]) begin bad++; $display("FAIL gap_step2: got %0d required %0d", sample_count, steps[2]); end
        for (int i = 3; i < 6; i++) begin
            send(8'd5);
            total++; if (sample_count !== steps[i]) begin bad++; $display("FAIL gap_step%0d: got %0d required %0d", i, sample_count, steps[i]); end
        end
        pop_result("gap");
        data_in    = 8'd9;
        data_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            total++; if (result !== 8'd20) begin bad++; $display("FAIL hold_result%0d: got %0d required 20", i, result); end
            total++; if (sample_count !== 8'd4) begin bad++; $display("FAIL hold_count%0d: got %0d required 4", i, sample_count); end
        end
        data_valid = 1'b0;
        do_ack("gap_ack");
    endtask

    task automatic test_clear();
        send(8'd7);
        send(8'd8);
        data_in    = 8'd50;
        data_valid = 1'b1;
        clear      = 1'b1;
        idle_cycle();
        data_valid = 1'b0;
        clear      = 1'b0;
        model_clear();
        total++; if (sample_count !== 8'd0) begin bad++; $display("FAIL clear_count: got %0d required 0", sample_count); end
        total++; if (data_ready !== 1'b1) begin bad++; $display("FAIL clear_ready: got %0d required 1", data_ready); end
        total++; if (overflow_flag !== 1'b0) begin bad++; $display("FAIL clear_ovf: got %0d required 0", overflow_flag); end
        send(8'd1);
        send(8'd2);
        send(8'd3);
        send(8'd4);
        pop_result("clear_batch");
        do_ack("clear_ack");
    endtask

    task automatic test_single();
        data_in1    = 8'd33;
        data_valid1 = 1'b1;
        idle_cycle();
        data_valid1 = 1'b0;
        total++; if (result_valid1 !== 1'b1) begin bad++; $display("FAIL single_valid: got %0d required 1", result_valid1); end
        total++; if (result1 !== 8'd33) begin bad++; $display("FAIL single_result: got %0d required 33", result1); end
        total++; if (sample_count1 !== 8'd1) begin bad++; $display("FAIL single_count: got %0d required 1", sample_count1); end
        result_ack1 = 1'b1;
        clear1      = 1'b1;
        idle_cycle();
        result_ack1 = 1'b0;
        clear1      = 1'b0;
        total++; if (result_valid1 !== 1'b0) begin bad++; $display("FAIL single_ackclr_valid: got %0d required 0", result_valid1); end
        total++; if (data_ready1 !== 1'b1) begin bad++; $display("FAIL single_ackclr_ready: got %0d required 1", data_ready1); end
        total++; if (sample_count1 !== 8'd0) begin bad++; $display("FAIL single_ackclr_count: got %0d required 0", sample_count1); end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        n_rst       = 1'b0;
        clear       = 1'b0;
        data_in     = 8'd0;
        data_valid  = 1'b0;
        result_ack  = 1'b0;
        clear1      = 1'b0;
        data_in1    = 8'd0;
        data_valid1 = 1'b0;
        result_ack1 = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        total++; if (data_ready !== 1'b1) begin bad++; $display("FAIL por_ready: got %0d required 1", data_ready); end
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL por_valid: got %0d required 0", result_valid); end
        @(negedge clk);
        n_rst = 1'b1;
        idle_cycle();

        test_reset();
        test_basic();
        test_wrap();
        test_gaps();
        test_clear();
        test_single();

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
